alu_8: RTL and testbench

- 8-bit registered ALU with Z/C/V status flags.
- Eight operations: add, subtract, AND, OR, XOR, shift-left, shift-right, pass-A.
- Sits as the execute-stage datapath of small CPU/accelerator blocks: operands and opcode in, result and flags registered out one cycle later.

---
 rtl/alu_8_pkg.sv | 16 +
 rtl/alu_8_comb.sv | 46 ++++
 rtl/alu_8.sv | 52 +++++
 tb/tb_alu_8.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_8_pkg.sv
// alu_8_pkg: opcode encodings and status flag bundle shared by the alu_8 datapath
package alu_8_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;
  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/alu_8_comb.sv
// alu_8_comb: combinational result and Z/C/V flags for one A/B/op triple
module alu_8_comb import alu_8_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             c,
  output logic             v
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0] sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // select result per opcode; the extra top bit of diff is the unsigned borrow
  always_comb begin
    y = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        {c, y} = sum;
        v = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        {c, y} = diff;
        v = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[M-1:0], 1'b0};
        c = a[M];
      end
      OP_SHR: begin
        y = {1'b0, a[M:1]};
        c = a[0];
      end
      default: y = a;
    endcase
    z = (y == '0);
  end
endmodule

// File: rtl/alu_8.sv
// alu_8: registered 8-op ALU with Z/C/V flags; ALU8_NEG_FLAG_EN adds a registered N (sign) output
module alu_8 import alu_8_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             out_valid
`ifdef ALU8_NEG_FLAG_EN
  ,
  output logic             N
`endif
);
  logic [WIDTH-1:0] y_d;
  flags_t f_d, f_q;
  alu_8_comb #(.WIDTH(WIDTH)) u_comb (
    .a(A),
    .b(B),
    .op(op),
    .y(y_d),
    .z(f_d.z),
    .c(f_d.c),
    .v(f_d.v)
  );
  // capture result and flags on valid input, hold otherwise; out_valid pulses per capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y <= '0;
      f_q <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y <= y_d;
        f_q <= f_d;
      end
    end
  end
  assign Z = f_q.z;
  assign C = f_q.c;
  assign V = f_q.v;
`ifdef ALU8_NEG_FLAG_EN
  assign N = Y[WIDTH-1];
`endif
endmodule

// File: tb/tb_alu_8.sv
// tb_alu_8: directed self-checking bench for alu_8
module tb_alu_8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] op = '0;
  logic [7:0] Y;
  logic Z, C, V, out_valid;
  int checks = 0;
  int errors = 0;
`ifdef ALU8_NEG_FLAG_EN
  logic N;
`endif

  alu_8 dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .op(op),
    .Y(Y),
    .Z(Z),
    .C(C),
    .V(V),
    .out_valid(out_valid)
`ifdef ALU8_NEG_FLAG_EN
    ,
    .N(N)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    @(negedge clk);
    A = a;
    B = b;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Y, Z, C, V, out_valid} !== 12'h000) begin
      errors++;
      $display("FAIL reset_init got %h want 000", {Y, Z, C, V, out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_add();
    drive(8'h05, 8'h03, 3'b000);
    checks++;
    if ({Y, Z, C, V, out_valid} !== {8'h08, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL add_basic got %h want %h", {Y, Z, C, V, out_valid}, {8'h08, 3'b000, 1'b1});
    end
    drive(8'hFF, 8'h01, 3'b000);
    checks++;
    if ({Y, Z, C, V, out_valid} !== {8'h00, 3'b110, 1'b1}) begin
      errors++;
      $display("FAIL add_carry got %h want %h", {Y, Z, C, V, out_valid}, {8'h00, 3'b110, 1'b1});
    end
    drive(8'h7F, 8'h01, 3'b000);
    checks++;
    if ({Y, Z, C, V, out_valid} !== {8'h80, 3'b001, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf got %h want %h", {Y, Z, C, V, out_valid}, {8'h80, 3'b001, 1'b1});
    end
`ifdef ALU8_NEG_FLAG_EN
    checks++;
    if (N !== 1'b1) begin
      errors++;
      $display("FAIL neg_flag got %b want 1", N);
    end
`endif
  endtask

  task automatic test_sub();
    drive(8'h05, 8'h03, 3'b001);
    checks++;
    if ({Y, Z, C, V} !== {8'h02, 3'b000}) begin
      errors++;
      $display("FAIL sub_basic got %h want %h", {Y, Z, C, V}, {8'h02, 3'b000});
    end
    drive(8'h00, 8'h01, 3'b001);
    checks++;
    if ({Y, Z, C, V} !== {8'hFF, 3'b010}) begin
      errors++;
      $display("FAIL sub_borrow got %h want %h", {Y, Z, C, V}, {8'hFF, 3'b010});
    end
    drive(8'h80, 8'h01, 3'b001);
    checks++;
    if ({Y, Z, C, V} !== {8'h7F, 3'b001}) begin
      errors++;
      $display("FAIL sub_ovf got %h want %h", {Y, Z, C, V}, {8'h7F, 3'b001});
    end
    drive(8'h37, 8'h37, 3'b001);
    checks++;
    if ({Y, Z, C, V} !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL sub_zero got %h want %h", {Y, Z, C, V}, {8'h00, 3'b100});
    end
  endtask

  task automatic test_logic();
    drive(8'hF0, 8'h0F, 3'b010);
    checks++;
    if ({Y, Z, C, V} !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL and got %h want %h", {Y, Z, C, V}, {8'h00, 3'b100});
    end
    drive(8'hF0, 8'h0F, 3'b011);
    checks++;
    if ({Y, Z, C, V} !== {8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL or got %h want %h", {Y, Z, C, V}, {8'hFF, 3'b000});
    end
    drive(8'hFF, 8'h0F, 3'b100);
    checks++;
    if ({Y, Z, C, V} !== {8'hF0, 3'b000}) begin
      errors++;
      $display("FAIL xor got %h want %h", {Y, Z, C, V}, {8'hF0, 3'b000});
    end
  endtask

  task automatic test_shift_pass();
    drive(8'h80, 8'hFF, 3'b101);
    checks++;
    if ({Y, Z, C, V} !== {8'h00, 3'b110}) begin
      errors++;
      $display("FAIL shl got %h want %h", {Y, Z, C, V}, {8'h00, 3'b110});
    end
    drive(8'h01, 8'hFF, 3'b110);
    checks++;
    if ({Y, Z, C, V} !== {8'h00, 3'b110}) begin
      errors++;
      $display("FAIL shr got %h want %h", {Y, Z, C, V}, {8'h00, 3'b110});
    end
    drive(8'h81, 8'h00, 3'b110);
    checks++;
    if ({Y, Z, C, V} !== {8'h40, 3'b010}) begin
      errors++;
      $display("FAIL shr_msb got %h want %h", {Y, Z, C, V}, {8'h40, 3'b010});
    end
    drive(8'h41, 8'h00, 3'b101);
    checks++;
    if ({Y, Z, C, V} !== {8'h82, 3'b000}) begin
      errors++;
      $display("FAIL shl_nc got %h want %h", {Y, Z, C, V}, {8'h82, 3'b000});
    end
    drive(8'hAA, 8'h55, 3'b111);
    checks++;
    if ({Y, Z, C, V} !== {8'hAA, 3'b000}) begin
      errors++;
      $display("FAIL pass got %h want %h", {Y, Z, C, V}, {8'hAA, 3'b000});
    end
  endtask

  task automatic test_hold();
    drive(8'h05, 8'h03, 3'b000);
    idle();
    A = 8'hFF;
    B = 8'hFF;
    op = 3'b001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Y, Z, C, V, out_valid} !== {8'h08, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d got %h want %h", i, {Y, Z, C, V, out_valid}, {8'h08, 3'b000, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    drive(8'hAA, 8'h00, 3'b111);
    checks++;
    if (Y !== 8'hAA) begin
      errors++;
      $display("FAIL rst_pre got %h want aa", Y);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({Y, Z, C, V, out_valid} !== 12'h000) begin
      errors++;
      $display("FAIL rst_async got %h want 000", {Y, Z, C, V, out_valid});
    end
    idle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Y, out_valid} !== 9'h000) begin
        errors++;
        $display("FAIL rst_idle%0d got %h want 000", i, {Y, out_valid});
      end
    end
    drive(8'h7F, 8'h01, 3'b000);
    checks++;
    if ({Y, Z, C, V, out_valid} !== {8'h80, 3'b001, 1'b1}) begin
      errors++;
      $display("FAIL rst_after got %h want %h", {Y, Z, C, V, out_valid}, {8'h80, 3'b001, 1'b1});
    end
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift_pass();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
